serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_if.sv | 34 +++
 rtl/serial_adder_ctrl.sv | 96 +++++++++
 tb/tb_serial_adder_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial add sequencer.
// The sub input exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_1;
    logic [WIDTH-1:0] d_2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif

    modport master (
        output in_valid, d_1, d_2, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, Sum, Cout, busy
    );

    modport slave (
        input  in_valid, d_1, d_2, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, Sum, Cout, busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: one FA slice, LSB first, registered carry.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready=1
// ST_RUN  | one sum bit per clock through the FA slice, busy=1
// ST_DONE | Sum/Cout held, out_valid=1 until out_ready
module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             carry_init;
    logic             fa_s;
    logic             fa_co;

    assign accept = bus.in_valid && (state == ST_IDLE);

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and seed the carry with 1.
    assign b_load     = bus.sub ? ~bus.d_2 : bus.d_2;
    assign carry_init = bus.sub;
`else
    assign b_load     = bus.d_2;
    assign carry_init = 1'b0;
`endif

    assign fa_s  = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_co = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_sr  <= bus.d_1;
                        b_sr  <= b_load;
                        carry <= carry_init;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Sum fills from the MSB side so bit 0 lands at Sum[0] last.
                    sum_q <= {fa_s, sum_q[WIDTH-1:1]};
                    carry <= fa_co;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        cout_q <= fa_co;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.busy      = (state == ST_RUN);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random
// operand pairs against an arithmetic reference (subtract if SERIAL_ADDER_SUB_EN).
module tb_serial_adder_ctrl;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    logic sub_drv;
    int   n_cmp;
    int   n_err;

    serial_adder_if #(.WIDTH(W)) bus ();

`ifdef SERIAL_ADDER_SUB_EN
    assign bus.sub = sub_drv;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {Cout,Sum} as plain (W+1)-bit arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sb);
        logic [W-1:0] nb;
        nb = ~b;
`ifdef SERIAL_ADDER_SUB_EN
        if (sb) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
`endif
        return {1'b0, a} + {1'b0, b};
    endfunction

    // One complete operation; called at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                          input int stall, input bit hold_req, input bit chk_lat);
        logic [W:0] exp;
        int cyc;
        int busy_cnt;
        exp = model(a, b, sb);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.out_ready = (stall == 0);
        bus.d_1       = a;
        bus.d_2       = b;
        sub_drv       = sb;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold_req) begin
            bus.d_1 = 16'h0001;
            bus.d_2 = 16'h0001;
        end else begin
            bus.in_valid = 1'b0;
            bus.d_1      = W'($urandom);
            bus.d_2      = W'($urandom);
        end
        sub_drv  = ~sb;
        cyc      = 0;
        busy_cnt = 0;
        while (!bus.out_valid && cyc < 4 * W) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        if (!bus.out_valid) begin
            chk("out_valid_timeout", 0, 1);
        end else begin
            chk("sum", bus.Sum, exp[W-1:0]);
            chk("cout", bus.Cout, exp[W]);
            chk("busy_at_done", bus.busy, 0);
            if (chk_lat) begin
                chk("latency", cyc, W);
                chk("busy_cycles", busy_cnt, W);
            end
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_sum", bus.Sum, exp[W-1:0]);
                chk("hold_cout", bus.Cout, exp[W]);
                if (hold_req) chk("hold_in_ready", bus.in_ready, 0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("in_ready_after_hs", bus.in_ready, 1);
            chk("out_valid_after_hs", bus.out_valid, 0);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        sub_drv       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.d_1       = '0;
        bus.d_2       = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sum", bus.Sum, 0);
        chk("rst_cout", bus.Cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 1'b1);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0, 1'b1);
        run_op(16'h8001, 16'h7FFF, 1'b0, 5, 1'b1, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b0, 1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a RUN.
        bus.d_1      = 16'hAAAA;
        bus.d_2      = 16'h5555;
        sub_drv      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_sum", bus.Sum, 0);
        chk("mid_rst_cout", bus.Cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h0003, 16'h0004, 1'b0, 0, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0, 1'b1);
        chk("sub_borrow_sum", bus.Sum, 16'hFFFE);
        chk("sub_borrow_cout", bus.Cout, 0);
        run_op(16'h0009, 16'h0002, 1'b1, 2, 1'b0, 1'b1);
        chk("sub_pos_sum", bus.Sum, 16'h0007);
        chk("sub_pos_cout", bus.Cout, 1);
`endif

        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`endif
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ra, rb, rs, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
